// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone command master.
package wbm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDAT,
    S_STB,
    S_DONE
  } wbm_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  function automatic int byte_en_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/wbm_cmd_master_if.sv
// Wishbone classic bus signals between the command master and a slave.
interface wbm_cmd_master_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic            wbm_we_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic [AW-1:0]   wbm_adr_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [DW-1:0]   wbm_dat_i;
  logic            wbm_ack_i;
  logic            wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wbm_timeout_ctr.sv
// Counts strobe cycles without a slave response; expired flags the abort point.
module wbm_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16,
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [CW-1:0] cnt_reg;

  assign expired = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en && !expired) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/wbm_cmd_master.sv
// Wishbone classic master: turns a read/write burst command into bus beats
// and reports OK / ERR / TIMEOUT on completion.
module wbm_cmd_master
  import wbm_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int BURST_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int BYTE_EN_WIDTH = byte_en_width(BUS_DATA_WIDTH)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [BYTE_EN_WIDTH-1:0]  cmd_sel_i,
  input  logic [BURST_WIDTH-1:0]    cmd_len_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [BUS_DATA_WIDTH-1:0] wr_dat_i,
  output logic                      rd_valid_o,
  output logic [BUS_DATA_WIDTH-1:0] rd_dat_o,
  output logic                      rd_last_o,
  output logic                      done_o,
  output logic [1:0]                status_o,
  wbm_cmd_master_if.master          wbm
);
  wbm_state_e                state_reg, state_next;
  logic [BURST_WIDTH-1:0]    cnt_reg, cnt_next;
  logic                      cyc_reg, cyc_next, stb_reg, stb_next, we_reg, we_next;
  logic [BYTE_EN_WIDTH-1:0]  sel_reg, sel_next;
  logic [BUS_ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic [BUS_DATA_WIDTH-1:0] dat_reg, dat_next, rd_dat_reg, rd_dat_next;
  logic                      cmd_ready_reg, cmd_ready_next, wr_ready_reg, wr_ready_next;
  logic                      rd_valid_reg, rd_valid_next, rd_last_reg, rd_last_next;
  logic                      done_reg, done_next;
  logic [1:0]                status_reg, status_next;
  logic                      to_clear, to_expired;

  // Counter only runs while a strobe is outstanding; any response restarts it.
  assign to_clear = (state_reg != S_STB) || wbm.wbm_ack_i || wbm.wbm_err_i;

  wbm_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (to_clear),
    .en      (state_reg == S_STB),
    .expired (to_expired)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cyc_next      = cyc_reg;
    stb_next      = stb_reg;
    we_next       = we_reg;
    sel_next      = sel_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    rd_dat_next   = rd_dat_reg;
    rd_last_next  = rd_last_reg;
    wr_ready_next = wr_ready_reg;
    rd_valid_next = 1'b0;
    done_next     = 1'b0;
    status_next   = status_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_reg) begin
          we_next  = cmd_we_i;
          adr_next = cmd_adr_i;
          sel_next = cmd_sel_i;
          cnt_next = cmd_len_i;
          cyc_next = 1'b1;
          if (cmd_we_i) begin
            wr_ready_next = 1'b1;
            state_next    = S_WDAT;
          end else begin
            stb_next   = 1'b1;
            state_next = S_STB;
          end
        end
      end
      S_WDAT: begin
        if (wr_valid_i) begin
          dat_next      = wr_dat_i;
          stb_next      = 1'b1;
          wr_ready_next = 1'b0;
          state_next    = S_STB;
        end
      end
      S_STB: begin
        // err beats a simultaneous ack; an ack beats an expiring timeout.
        if (wbm.wbm_err_i || (!wbm.wbm_ack_i && to_expired)) begin
          cyc_next    = 1'b0;
          stb_next    = 1'b0;
          status_next = wbm.wbm_err_i ? ST_ERR : ST_TIMEOUT;
          done_next   = 1'b1;
          state_next  = S_DONE;
        end else if (wbm.wbm_ack_i) begin
          if (!we_reg) begin
            rd_valid_next = 1'b1;
            rd_dat_next   = wbm.wbm_dat_i;
            rd_last_next  = (cnt_reg == '0);
          end
          if (cnt_reg == '0) begin
            cyc_next    = 1'b0;
            stb_next    = 1'b0;
            status_next = ST_OK;
            done_next   = 1'b1;
            state_next  = S_DONE;
          end else begin
            adr_next = adr_reg + BUS_ADDR_WIDTH'(1);
            cnt_next = cnt_reg - BURST_WIDTH'(1);
            if (we_reg) begin
              stb_next      = 1'b0;
              wr_ready_next = 1'b1;
              state_next    = S_WDAT;
            end
          end
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    cmd_ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rd_dat_reg    <= '0;
      rd_last_reg   <= 1'b0;
      rd_valid_reg  <= 1'b0;
      wr_ready_reg  <= 1'b0;
      cmd_ready_reg <= 1'b1;
      done_reg      <= 1'b0;
      status_reg    <= ST_OK;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      rd_dat_reg    <= rd_dat_next;
      rd_last_reg   <= rd_last_next;
      rd_valid_reg  <= rd_valid_next;
      wr_ready_reg  <= wr_ready_next;
      cmd_ready_reg <= cmd_ready_next;
      done_reg      <= done_next;
      status_reg    <= status_next;
    end
  end

  assign cmd_ready_o   = cmd_ready_reg;
  assign wr_ready_o    = wr_ready_reg;
  assign rd_valid_o    = rd_valid_reg;
  assign rd_dat_o      = rd_dat_reg;
  assign rd_last_o     = rd_last_reg;
  assign done_o        = done_reg;
  assign status_o      = status_reg;
  assign wbm.wbm_cyc_o = cyc_reg;
  assign wbm.wbm_stb_o = stb_reg;
  assign wbm.wbm_we_o  = we_reg;
  assign wbm.wbm_sel_o = sel_reg;
  assign wbm.wbm_adr_o = adr_reg;
  assign wbm.wbm_dat_o = dat_reg;
endmodule
